// File: rtl/lut_pkg.sv
// Shared definitions for the lookup-table mapper: default-fill encodings,
// sequencer state encoding and the default-pattern generator.
package lut_pkg;

  localparam int LUT_INIT_INC  = 0;
  localparam int LUT_INIT_ZERO = 1;
  localparam int LUT_INIT_ID   = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } lut_state_t;

  // Default content of table entry 'index'; computed wide, then wrapped to 'width' bits.
  function automatic logic [63:0] init_value(input int mode, input logic [31:0] index,
                                             input int width);
    logic [63:0] v;
    logic [63:0] mask;
    case (mode)
      LUT_INIT_INC:  v = 64'(index) + 64'd1;
      LUT_INIT_ZERO: v = 64'd0;
      LUT_INIT_ID:   v = 64'(index);
      default:       v = 64'd0;
    endcase
    if (width >= 64) mask = '1;
    else             mask = (64'd1 << width) - 64'd1;
    return v & mask;
  endfunction

endpackage

// File: rtl/lut_pipe_ram.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational
// read port. A read of the address being written this cycle sees the new data.
module lut_pipe_ram #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Table storage; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  // Write-first bypass so a same-cycle write is visible to the reader.
  always_comb begin
    rdata = mem[raddr];
    if (we && (waddr == raddr)) rdata = wdata;
  end

endmodule

// File: rtl/lut_pipe_mapper.sv
// Runtime-writable code-mapping table with a two-stage valid/ready read pipe
// and an init sequencer that fills every entry with a default pattern.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | writing pattern(cnt) to entry cnt, one per cycle; busy=1
//   ST_IDLE | serving lookups and host writes; init_req restarts fill
module lut_pipe_mapper
  import lut_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 3,
  parameter int INIT_MODE  = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  init_req,
  output logic                  busy,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOG2_DEPTH-1:0] in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  strobe,
  input  logic                  wr_en,
  input  logic [LOG2_DEPTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data
);

  localparam logic [LOG2_DEPTH-1:0] CNT_LAST = '1;

  lut_state_t            state;
  logic [LOG2_DEPTH-1:0] cnt;

  logic                  s1_valid;
  logic [LOG2_DEPTH-1:0] s1_addr;

  logic                  s2_adv;
  logic                  s1_adv;
  logic                  accept;

  logic                  ram_we;
  logic [LOG2_DEPTH-1:0] ram_waddr;
  logic [WIDTH-1:0]      ram_wdata;
  logic [WIDTH-1:0]      ram_rdata;
  logic [WIDTH-1:0]      init_word;

  assign busy     = (state == ST_INIT);
  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = !busy && s1_adv;
  assign accept   = in_valid && in_ready;

  assign init_word = WIDTH'(init_value(INIT_MODE, 32'(cnt), WIDTH));

  // The sequencer owns the write port while filling; host writes are dropped then.
  always_comb begin
    ram_we    = wr_en;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (busy) begin
      ram_we    = 1'b1;
      ram_waddr = cnt;
      ram_wdata = init_word;
    end
  end

  lut_pipe_ram #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (s1_addr),
    .rdata (ram_rdata)
  );

  // Init sequencer: DEPTH fill cycles, then idle until the next request.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_INIT;
      cnt   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (init_req) begin
            state <= ST_INIT;
            cnt   <= '0;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Read pipe: S1 holds the address, S2 the looked-up word; strobe marks each handshake.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid  <= 1'b0;
      s1_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      strobe    <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) s1_addr <= in_addr;
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) out_data <= ram_rdata;
      end
      strobe <= out_valid && out_ready;
    end
  end

endmodule

// File: tb/tb_lut_pipe_mapper.sv
// Scoreboard bench for lut_pipe_mapper: the driver pushes expected words on
// each accepted request, a negedge monitor pops and compares on each result.
module tb_lut_pipe_mapper;

  logic       clock;
  logic       reset_n;
  logic       init_req;
  logic       in_valid;
  logic [2:0] in_addr;
  logic       out_ready;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       strobe;

  // two narrow instances for the wrap-around patterns
  logic       s_in_valid;
  logic [2:0] s_in_addr;
  logic       a_busy, a_in_ready, a_out_valid, a_strobe;
  logic [1:0] a_out_data;
  logic       b_busy, b_in_ready, b_out_valid, b_strobe;
  logic [1:0] b_out_data;

  lut_pipe_mapper dut (
    .clock(clock), .reset_n(reset_n), .init_req(init_req), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .strobe(strobe), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  lut_pipe_mapper #(.WIDTH(2), .LOG2_DEPTH(3), .INIT_MODE(0)) dut_w2_inc (
    .clock(clock), .reset_n(reset_n), .init_req(1'b0), .busy(a_busy),
    .in_valid(s_in_valid), .in_ready(a_in_ready), .in_addr(s_in_addr),
    .out_valid(a_out_valid), .out_ready(1'b1), .out_data(a_out_data),
    .strobe(a_strobe), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(2'd0)
  );

  lut_pipe_mapper #(.WIDTH(2), .LOG2_DEPTH(3), .INIT_MODE(2)) dut_w2_id (
    .clock(clock), .reset_n(reset_n), .init_req(1'b0), .busy(b_busy),
    .in_valid(s_in_valid), .in_ready(b_in_ready), .in_addr(s_in_addr),
    .out_valid(b_out_valid), .out_ready(1'b1), .out_data(b_out_data),
    .strobe(b_strobe), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(2'd0)
  );

  typedef struct {
    logic [7:0] data;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_cnt = 0;
  bit         prev_hs = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: strobe follows handshakes, stalled outputs hold, results match queue.
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_hs    = 0;
      prev_stall = 0;
    end else begin
      check("strobe", {31'd0, strobe}, {31'd0, prev_hs});
      if (prev_stall) begin
        check("stall_valid", {31'd0, out_valid}, 32'd1);
        check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got 0x%0h, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.data});
          if (e.lat) check("latency", cyc - e.acc, 32'd2);
        end
      end
      prev_hs    = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic sync();
    @(posedge clock);
    #1;
  endtask

  // Must be called 1 time unit after a posedge; returns 1 unit after the accept edge.
  task automatic send(input logic [2:0] a, input logic [7:0] d, input bit lat);
    int t = 0;
    exp_t x;
    in_valid = 1'b1;
    in_addr  = a;
    forever begin
      @(negedge clock);
      if (in_ready) begin
        x.data = d; x.acc = cyc; x.lat = lat;
        exp_q.push_back(x);
        acc_cnt++;
        break;
      end
      t++;
      if (t > 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: addr %0d never accepted, expected accept", a);
        break;
      end
      @(posedge clock);
      #1;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clock);
      t++;
    end
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  // Counts negedges with busy high, starting at the current negedge.
  task automatic busy_cycles(input bit poke, output int n);
    n = 0;
    while (busy && n < 50) begin
      if (poke) init_req = (n == 3);
      n++;
      @(negedge clock);
    end
    init_req = 1'b0;
  endtask

  task automatic small_check(input logic [2:0] a, input logic [1:0] ea, input logic [1:0] eb);
    s_in_valid = 1'b1;
    s_in_addr  = a;
    @(posedge clock);
    #1;
    s_in_valid = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    check("w2_inc_valid", {31'd0, a_out_valid}, 32'd1);
    check("w2_inc_data", {30'd0, a_out_data}, {30'd0, ea});
    check("w2_id_data", {30'd0, b_out_data}, {30'd0, eb});
  endtask

  initial begin
    int n;
    int base;
    reset_n = 1'b0; init_req = 1'b0; in_valid = 1'b0; in_addr = '0;
    out_ready = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    s_in_valid = 1'b0; s_in_addr = '0;

    // reset state and init length
    repeat (2) @(negedge clock);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_strobe", {31'd0, strobe}, 32'd0);
    reset_n = 1'b1;
    busy_cycles(1'b0, n);
    check("busy_len_reset", n, 32'd8);

    // WIDTH=2 wrap-around: mode 0 and mode 2
    small_check(3'd3, 2'd0, 2'd3);
    small_check(3'd7, 2'd0, 2'd3);
    small_check(3'd5, 2'd2, 2'd1);

    // back-to-back lookups 0..7 -> 1..8, latency 2, continuous strobe
    sync();
    for (int i = 0; i < 8; i++) send(3'(i), 8'(i + 1), 1'b1);
    drain();

    // backpressure burst; write into the entry held in S2 during the stall
    sync();
    out_ready = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(3'd0, 8'h01, 1'b0);
        send(3'd1, 8'h02, 1'b0);
        send(3'd2, 8'h03, 1'b0);
        send(3'd3, 8'h04, 1'b0);
      end
      begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check("stall_accepts", acc_cnt - base, 32'd2);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h33;
        @(posedge clock);
        #1;
        wr_en = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    sync();
    send(3'd0, 8'h33, 1'b0);

    // write-first collision on addr 4
    drain();
    sync();
    send(3'd4, 8'hAA, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'hAA;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    send(3'd4, 8'hAA, 1'b0);
    drain();

    // re-init with results in flight; host writes and repeat requests ignored
    sync();
    send(3'd1, 8'h02, 1'b0);
    send(3'd2, 8'h03, 1'b0);
    init_req = 1'b1;
    @(posedge clock);
    #1;
    init_req = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd4; wr_data = 8'h55;
    check("init_busy", {31'd0, busy}, 32'd1);
    check("init_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clock);
    busy_cycles(1'b1, n);
    wr_en = 1'b0;
    check("busy_len_req", n, 32'd8);
    sync();
    send(3'd4, 8'h05, 1'b0);
    send(3'd0, 8'h01, 1'b0);
    send(3'd2, 8'h03, 1'b0);
    drain();

    // asynchronous reset mid-stream
    sync();
    send(3'd3, 8'h04, 1'b0);
    send(3'd5, 8'h06, 1'b0);
    send(3'd6, 8'h07, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_strobe", {31'd0, strobe}, 32'd0);
    check("arst_out_data", {24'd0, out_data}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd1);
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    busy_cycles(1'b0, n);
    check("busy_len_arst", n, 32'd8);
    sync();
    send(3'd4, 8'h05, 1'b0);
    send(3'd7, 8'h08, 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
